// File: rtl/pong_game_ctrl_pkg.sv
// rtl/pong_game_ctrl_pkg.sv - shared state encoding and winner codes for the pong game controller
// Contents: FSM state constants (IDLE..OVER), winner codes, and a helper
// that tells whether a state holds the ball at screen centre.
package pong_game_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    // PAUSE freezes the ball where it is, so it is deliberately not centred.
    function automatic logic holds_center(input logic [2:0] st);
        return (st == ST_IDLE) || (st == ST_SERVE) || (st == ST_OVER);
    endfunction

endpackage

// File: rtl/pong_game_ctrl_frame_timer.sv
// rtl/pong_game_ctrl_frame_timer.sv - serve delay down-counter counting frame ticks
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   load, load_val  load the counter (takes priority over tick_en)
//   tick_en         decrement by one this cycle
//   done            combinational: this tick is the one that reaches zero
module frame_timer (
    input  logic       CLK,
    input  logic       RST,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       tick_en,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (tick_en && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    // Flagged on the final tick itself so the FSM leaves SERVE on the same
    // edge that the counter reaches zero.
    assign done = tick_en && !load && (count == 8'd1);

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game state machine, serve timing and score keeping
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   start                 start/pause pulse
//   frame_tick            one pulse per video frame
//   miss_l, miss_r        ball passed left / right edge
//   ball_run, ball_center ball motion enable / hold at centre
//   serve_dir             0 = serve toward left, 1 = toward right
//   score_l, score_r      player scores
//   winner                01 left, 10 right, 00 none
//   state                 current FSM state
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic       ball_run,
    output logic       ball_center,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam logic [3:0] WIN_PTS    = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);

    logic [2:0] next_state;
    logic [3:0] next_score_l;
    logic [3:0] next_score_r;
    logic [1:0] next_winner;
    logic       next_dir;
    logic       timer_load;
    logic       timer_done;

    frame_timer u_frame_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (timer_load),
        .load_val (SERVE_LOAD),
        .tick_en  ((state == ST_SERVE) && frame_tick),
        .done     (timer_done)
    );

    always_comb begin
        next_state   = state;
        next_score_l = score_l;
        next_score_r = score_r;
        next_winner  = winner;
        next_dir     = serve_dir;
        timer_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state   = ST_SERVE;
                    next_score_l = 4'd0;
                    next_score_r = 4'd0;
                    timer_load   = 1'b1;
                end
            end
            ST_SERVE: begin
                if (timer_done) begin
                    next_state = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A miss always beats a coincident start.
                if (miss_l && miss_r) begin
                    next_state = ST_SERVE;
                    timer_load = 1'b1;
                end else if (miss_l) begin
                    next_score_r = score_r + 4'd1;
                    next_dir     = 1'b0;
                    if (next_score_r == WIN_PTS) begin
                        next_state  = ST_OVER;
                        next_winner = WIN_RIGHT;
                    end else begin
                        next_state = ST_SERVE;
                        timer_load = 1'b1;
                    end
                end else if (miss_r) begin
                    next_score_l = score_l + 4'd1;
                    next_dir     = 1'b1;
                    if (next_score_l == WIN_PTS) begin
                        next_state  = ST_OVER;
                        next_winner = WIN_LEFT;
                    end else begin
                        next_state = ST_SERVE;
                        timer_load = 1'b1;
                    end
                end else if (start) begin
                    next_state = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (start) begin
                    next_state = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (start) begin
                    next_state   = ST_SERVE;
                    next_score_l = 4'd0;
                    next_score_r = 4'd0;
                    next_winner  = WIN_NONE;
                    next_dir     = 1'b0;
                    timer_load   = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Ball controls are derived from next_state so they line up with state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            score_l     <= 4'd0;
            score_r     <= 4'd0;
            winner      <= WIN_NONE;
            serve_dir   <= 1'b0;
            ball_run    <= 1'b0;
            ball_center <= 1'b1;
        end else begin
            state       <= next_state;
            score_l     <= next_score_l;
            score_r     <= next_score_r;
            winner      <= next_winner;
            serve_dir   <= next_dir;
            ball_run    <= (next_state == ST_PLAY);
            ball_center <= holds_center(next_state);
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - self-checking bench for pong_game_ctrl
module tb_pong_game_ctrl;

    localparam int WIN = 7;
    localparam int SF  = 60;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic       miss_l = 1'b0;
    logic       miss_r = 1'b0;
    logic       ball_run;
    logic       ball_center;
    logic       serve_dir;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] winner;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the game rules.
    logic [2:0] m_st;
    logic [3:0] m_sl;
    logic [3:0] m_sr;
    logic [1:0] m_win;
    logic       m_dir;
    int         m_cnt;

    pong_game_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF)) dut (
        .CLK         (clk),
        .RST         (rst),
        .start       (start),
        .frame_tick  (frame_tick),
        .miss_l      (miss_l),
        .miss_r      (miss_r),
        .ball_run    (ball_run),
        .ball_center (ball_center),
        .serve_dir   (serve_dir),
        .score_l     (score_l),
        .score_r     (score_r),
        .winner      (winner),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = S_IDLE; m_sl = 0; m_sr = 0; m_win = 2'b00; m_dir = 1'b0; m_cnt = 0;
    endtask

    task automatic model_step(input logic s, input logic t, input logic l, input logic r);
        case (m_st)
            S_IDLE: if (s) begin m_st = S_SERVE; m_sl = 0; m_sr = 0; m_cnt = SF; end
            S_SERVE: if (t) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_st = S_PLAY;
            end
            S_PLAY: begin
                if (l && r) begin
                    m_st = S_SERVE; m_cnt = SF;
                end else if (l) begin
                    m_sr = m_sr + 1; m_dir = 1'b0;
                    if (int'(m_sr) == WIN) begin m_st = S_OVER; m_win = 2'b10; end
                    else begin m_st = S_SERVE; m_cnt = SF; end
                end else if (r) begin
                    m_sl = m_sl + 1; m_dir = 1'b1;
                    if (int'(m_sl) == WIN) begin m_st = S_OVER; m_win = 2'b01; end
                    else begin m_st = S_SERVE; m_cnt = SF; end
                end else if (s) begin
                    m_st = S_PAUSE;
                end
            end
            S_PAUSE: if (s) m_st = S_PLAY;
            S_OVER: if (s) begin
                m_st = S_SERVE; m_sl = 0; m_sr = 0; m_win = 2'b00; m_dir = 1'b0; m_cnt = SF;
            end
            default: ;
        endcase
    endtask

    // One clock with the given inputs; returns at posedge + 1.
    task automatic cyc(input logic s, input logic t, input logic l, input logic r);
        start = s; frame_tick = t; miss_l = l; miss_r = r;
        @(posedge clk);
        model_step(s, t, l, r);
        #1;
        start = 0; frame_tick = 0; miss_l = 0; miss_r = 0;
    endtask

    task automatic serve_out();
        for (int i = 0; i < SF; i++) cyc(0, 1, 0, 0);
    endtask

    task automatic test_reset();
        model_reset();
        @(posedge clk); #1;
        n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", state, S_IDLE); end
        n_checks++; if ({score_l, score_r} !== 8'h00) begin n_fail++; $display("FAIL reset_scores got %h exp 00", {score_l, score_r}); end
        n_checks++; if (winner !== 2'b00) begin n_fail++; $display("FAIL reset_winner got %b exp 00", winner); end
        n_checks++; if ({serve_dir, ball_run, ball_center} !== 3'b001) begin n_fail++; $display("FAIL reset_ball got %b exp 001", {serve_dir, ball_run, ball_center}); end
        rst = 1'b0;
        cyc(0, 1, 1, 1);
        n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL idle_ignores got %0d exp %0d", state, S_IDLE); end
    endtask

    task automatic test_serve();
        cyc(1, 1, 0, 0);  // tick coincident with SERVE entry must not count
        n_checks++; if (state !== S_SERVE) begin n_fail++; $display("FAIL serve_entry got %0d exp %0d", state, S_SERVE); end
        for (int i = 1; i < SF; i++) begin
            cyc(0, 1, 0, 0);
            cyc(1, 0, 1, 1);  // start and misses ignored in SERVE
        end
        n_checks++; if (state !== S_SERVE || ball_run !== 1'b0) begin n_fail++; $display("FAIL serve_59 got st %0d run %b exp st 1 run 0", state, ball_run); end
        cyc(0, 1, 0, 0);
        n_checks++; if (state !== S_PLAY || ball_run !== 1'b1 || ball_center !== 1'b0) begin n_fail++; $display("FAIL serve_60 got st %0d run %b ctr %b exp st 2 run 1 ctr 0", state, ball_run, ball_center); end
    endtask

    task automatic test_win();
        for (int k = 1; k <= WIN; k++) begin
            cyc(0, 0, 0, 1);
            if (k < WIN) begin
                n_checks++; if (state !== S_SERVE || serve_dir !== 1'b1 || score_l !== 4'(k)) begin n_fail++; $display("FAIL point_%0d got st %0d dir %b sl %0d exp st 1 dir 1 sl %0d", k, state, serve_dir, score_l, k); end
                serve_out();
            end
        end
        n_checks++; if (score_l !== 4'd7 || state !== S_OVER || winner !== 2'b01) begin n_fail++; $display("FAIL game_over got sl %0d st %0d win %b exp sl 7 st 4 win 01", score_l, state, winner); end
        cyc(0, 1, 0, 1);
        n_checks++; if (score_l !== 4'd7 || state !== S_OVER || ball_center !== 1'b1) begin n_fail++; $display("FAIL over_frozen got sl %0d st %0d ctr %b exp sl 7 st 4 ctr 1", score_l, state, ball_center); end
    endtask

    task automatic test_both_miss();
        cyc(1, 0, 0, 0);
        n_checks++; if (state !== S_SERVE || {score_l, score_r} !== 8'h00 || winner !== 2'b00 || serve_dir !== 1'b0) begin n_fail++; $display("FAIL restart got st %0d sc %h win %b dir %b exp 1 00 00 0", state, {score_l, score_r}, winner, serve_dir); end
        serve_out();
        cyc(0, 0, 0, 1);
        serve_out();
        cyc(0, 0, 1, 1);
        n_checks++; if (state !== S_SERVE || score_l !== 4'd1 || score_r !== 4'd0 || serve_dir !== 1'b1) begin n_fail++; $display("FAIL both_miss got st %0d sl %0d sr %0d dir %b exp 1 1 0 1", state, score_l, score_r, serve_dir); end
        serve_out();
    endtask

    task automatic test_pause();
        cyc(1, 0, 0, 0);
        n_checks++; if (state !== S_PAUSE || ball_run !== 1'b0 || ball_center !== 1'b0) begin n_fail++; $display("FAIL pause_enter got st %0d run %b ctr %b exp 3 0 0", state, ball_run, ball_center); end
        cyc(0, 1, 1, 0);
        n_checks++; if (state !== S_PAUSE || score_r !== 4'd0) begin n_fail++; $display("FAIL pause_miss got st %0d sr %0d exp 3 0", state, score_r); end
        cyc(1, 0, 0, 0);
        n_checks++; if (state !== S_PLAY || ball_run !== 1'b1) begin n_fail++; $display("FAIL pause_exit got st %0d run %b exp 2 1", state, ball_run); end
        cyc(1, 0, 1, 0);  // miss beats start
        n_checks++; if (state !== S_SERVE || score_r !== 4'd1 || serve_dir !== 1'b0) begin n_fail++; $display("FAIL miss_wins got st %0d sr %0d dir %b exp 1 1 0", state, score_r, serve_dir); end
        serve_out();
    endtask

    task automatic test_async_reset();
        cyc(0, 0, 0, 1); serve_out();
        cyc(0, 0, 0, 1); serve_out();
        cyc(0, 0, 1, 0); serve_out();
        n_checks++; if (state !== S_PLAY || score_l !== 4'd3 || score_r !== 4'd2) begin n_fail++; $display("FAIL pre_reset got st %0d sl %0d sr %0d exp 2 3 2", state, score_l, score_r); end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_checks++; if (state !== S_IDLE || {score_l, score_r} !== 8'h00 || winner !== 2'b00 || {serve_dir, ball_run, ball_center} !== 3'b001) begin n_fail++; $display("FAIL async_reset got st %0d sc %h win %b ball %b exp 0 00 00 001", state, {score_l, score_r}, winner, {serve_dir, ball_run, ball_center}); end
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1, 0, 0, 0);
        n_checks++; if (state !== S_SERVE || {score_l, score_r} !== 8'h00) begin n_fail++; $display("FAIL post_reset_start got st %0d sc %h exp 1 00", state, {score_l, score_r}); end
    endtask

    task automatic test_random();
        logic s, t, l, r;
        for (int i = 0; i < 4000; i++) begin
            s = ($urandom_range(0, 39) == 0);
            t = ($urandom_range(0, 1) == 0);
            l = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 7) == 0);
            cyc(s, t, l, r);
            n_checks++;
            if ({state, score_l, score_r, winner, serve_dir, ball_run, ball_center} !==
                {m_st, m_sl, m_sr, m_win, m_dir, (m_st == S_PLAY),
                 (m_st == S_IDLE || m_st == S_SERVE || m_st == S_OVER)}) begin
                n_fail++;
                $display("FAIL random_cycle_%0d got st %0d sl %0d sr %0d win %b dir %b run %b ctr %b exp st %0d sl %0d sr %0d win %b dir %b",
                         i, state, score_l, score_r, winner, serve_dir, ball_run, ball_center, m_st, m_sl, m_sr, m_win, m_dir);
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_win();
        test_both_miss();
        test_pause();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
